// File: rtl/issue_queue.sv
// Out-of-order issue buffer: a compacting queue (slot 0 oldest) that wakes entries
// from writeback tags and offers the oldest entry whose two source operands are ready.
module issue_queue #(
  parameter int DEPTH       = 8,
  parameter int NR_WB_PORTS = 5,
  parameter int TAG_W       = 3,
  parameter int PAYLOAD_W   = 64,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PAYLOAD_W-1:0]         in_payload_i,
  input  logic [TAG_W-1:0]             in_trans_id_i,
  input  logic [TAG_W-1:0]             in_rs1_tag_i,
  input  logic                         in_rs1_rdy_i,
  input  logic [TAG_W-1:0]             in_rs2_tag_i,
  input  logic                         in_rs2_rdy_i,
  input  logic [NR_WB_PORTS-1:0]       wb_valid_i,
  input  logic [NR_WB_PORTS*TAG_W-1:0] wb_tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic [TAG_W-1:0]             out_trans_id_o,
  output logic [CNT_W-1:0]             count_o
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [TAG_W-1:0]     trans_id;
    logic [TAG_W-1:0]     rs1_tag;
    logic                 rs1_rdy;
    logic [TAG_W-1:0]     rs2_tag;
    logic                 rs2_rdy;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           q_up  [DEPTH];
  entry_t           q_n   [DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] ins_pos;
  logic [IDX_W-1:0] ins_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             ins_fire;
  logic             issue_fire;

  // Valid slots are exactly [0, count): compaction keeps them contiguous.
  function automatic logic wb_hit(input logic [TAG_W-1:0]             tag,
                                  input logic [NR_WB_PORTS-1:0]       v,
                                  input logic [NR_WB_PORTS*TAG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (v[p] && (t[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Each slot's younger neighbour, used when the queue compacts after an issue.
  for (genvar g = 0; g < DEPTH; g++) begin : g_up
    if (g < DEPTH - 1) begin : g_shift
      assign q_up[g] = q[g+1];
    end else begin : g_top
      assign q_up[g] = q[g];
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((i < int'(count)) && q[i].rs1_rdy && q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign in_ready_o     = (count < CNT_W'(DEPTH)) & ~rst_i;
  assign out_valid_o    = sel_found & ~rst_i & ~flush_i;
  assign out_payload_o  = q[sel_idx].payload;
  assign out_trans_id_o = q[sel_idx].trans_id;
  assign count_o        = count;

  assign ins_fire   = in_valid_i & in_ready_o & ~flush_i;
  assign issue_fire = out_valid_o & out_ready_i;
  assign ins_pos    = count - CNT_W'(issue_fire);
  assign ins_idx    = ins_pos[IDX_W-1:0];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_n[i] = q[i];
      if (issue_fire && (i >= int'(sel_idx))) q_n[i] = q_up[i];
      q_n[i].rs1_rdy = q_n[i].rs1_rdy | wb_hit(q_n[i].rs1_tag, wb_valid_i, wb_tag_i);
      q_n[i].rs2_rdy = q_n[i].rs2_rdy | wb_hit(q_n[i].rs2_tag, wb_valid_i, wb_tag_i);
      // A new entry also sees writebacks of its own insert cycle.
      if (ins_fire && (IDX_W'(i) == ins_idx)) begin
        q_n[i].payload  = in_payload_i;
        q_n[i].trans_id = in_trans_id_i;
        q_n[i].rs1_tag  = in_rs1_tag_i;
        q_n[i].rs1_rdy  = in_rs1_rdy_i | wb_hit(in_rs1_tag_i, wb_valid_i, wb_tag_i);
        q_n[i].rs2_tag  = in_rs2_tag_i;
        q_n[i].rs2_rdy  = in_rs2_rdy_i | wb_hit(in_rs2_tag_i, wb_valid_i, wb_tag_i);
      end
    end
  end

  always_comb begin
    count_n = count + CNT_W'(ins_fire) - CNT_W'(issue_fire);
    if (flush_i) count_n = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count <= '0;
    else       count <= count_n;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed, table-driven bench for issue_queue: one table row per clock cycle,
// followed by hand-written flush and asynchronous-reset sequences.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int NWB   = 5;
  localparam int TW    = 3;
  localparam int PW    = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PW-1:0]     in_payload;
  logic [TW-1:0]     in_trans_id;
  logic [TW-1:0]     in_rs1_tag;
  logic              in_rs1_rdy;
  logic [TW-1:0]     in_rs2_tag;
  logic              in_rs2_rdy;
  logic [NWB-1:0]    wb_valid;
  logic [NWB*TW-1:0] wb_tag;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     out_payload;
  logic [TW-1:0]     out_trans_id;
  logic [CW-1:0]     count;

  issue_queue #(.DEPTH(DEPTH), .NR_WB_PORTS(NWB), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_payload_i(in_payload),
    .in_trans_id_i(in_trans_id), .in_rs1_tag_i(in_rs1_tag), .in_rs1_rdy_i(in_rs1_rdy),
    .in_rs2_tag_i(in_rs2_tag), .in_rs2_rdy_i(in_rs2_rdy),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_payload_o(out_payload),
    .out_trans_id_o(out_trans_id), .count_o(count)
  );

  // Clock: posedge at 5, 15, ...; inputs change at negedge, outputs sampled 2 ns later.
  always #5 clk = ~clk;

  typedef struct {
    logic           fl;
    logic           iv;
    logic [TW-1:0]  id;
    logic [TW-1:0]  r1t;
    logic           r1r;
    logic [TW-1:0]  r2t;
    logic           r2r;
    logic [NWB-1:0] wbv;
    logic [NWB*TW-1:0] wbt;
    logic           ordy;
    logic           e_ov;
    logic [TW-1:0]  e_id;
    logic [CW-1:0]  e_cnt;
    logic           e_irdy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [PW-1:0] pl(input logic [TW-1:0] id);
    return {32'hC0DE_0000, 29'h0, id};
  endfunction

  function automatic vec_t mk(input logic fl, iv, input logic [TW-1:0] id, r1t,
                              input logic r1r, input logic [TW-1:0] r2t, input logic r2r,
                              input logic [NWB-1:0] wbv, input logic [NWB*TW-1:0] wbt,
                              input logic ordy, e_ov, input logic [TW-1:0] e_id,
                              input logic [CW-1:0] e_cnt, input logic e_irdy);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.r1t = r1t; v.r1r = r1r; v.r2t = r2t; v.r2r = r2r;
    v.wbv = wbv; v.wbt = wbt; v.ordy = ordy;
    v.e_ov = e_ov; v.e_id = e_id; v.e_cnt = e_cnt; v.e_irdy = e_irdy;
    return v;
  endfunction

  // Shorthands: ready insert, idle cycle.
  function automatic vec_t ins(input logic [TW-1:0] id, input logic ordy, e_ov,
                               input logic [TW-1:0] e_id, input logic [CW-1:0] e_cnt,
                               input logic e_irdy);
    return mk(0, 1, id, 0, 1, 0, 1, 0, 0, ordy, e_ov, e_id, e_cnt, e_irdy);
  endfunction

  function automatic vec_t idle(input logic ordy, e_ov, input logic [TW-1:0] e_id,
                                input logic [CW-1:0] e_cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, e_ov, e_id, e_cnt, 1);
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush       = v.fl;
    in_valid    = v.iv;
    in_trans_id = v.id;
    in_payload  = pl(v.id);
    in_rs1_tag  = v.r1t;
    in_rs1_rdy  = v.r1r;
    in_rs2_tag  = v.r2t;
    in_rs2_rdy  = v.r2r;
    wb_valid    = v.wbv;
    wb_tag      = v.wbt;
    out_ready   = v.ordy;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, " out_valid"}, PW'(out_valid), PW'(v.e_ov));
    chk({tag, " count"},     PW'(count),     PW'(v.e_cnt));
    chk({tag, " in_ready"},  PW'(in_ready),  PW'(v.e_irdy));
    if (v.e_ov) begin
      chk({tag, " trans_id"}, PW'(out_trans_id), PW'(v.e_id));
      chk({tag, " payload"},  out_payload,       pl(v.e_id));
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #2;
    check_outputs(tag, v);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    drive(mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    #2;
    check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    drive(idle(0, 0, 0, 0));

    // Insert-to-offer latency and issue.
    vecs.push_back(ins(1, 1, 0, 0, 0, 1));
    vecs.push_back(idle(1, 1, 1, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // Younger ready entry passes an older blocked one; wrong tag does not wake; tag 5 on port 3 does.
    vecs.push_back(mk(0, 1, 2, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(ins(3, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'b00010, 15'(6) << 3, 0, 1, 3, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'b01000, 15'(5) << 9, 0, 1, 3, 2, 1));
    vecs.push_back(idle(1, 1, 2, 2));
    vecs.push_back(idle(1, 1, 3, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // Same-cycle wakeup bypass on rs2.
    vecs.push_back(mk(0, 1, 4, 0, 1, 4, 0, 5'b00001, 15'd4, 0, 0, 0, 0, 1));
    vecs.push_back(idle(1, 1, 4, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // Fill to DEPTH, then issue at full with a refused insert.
    for (int k = 0; k < DEPTH; k++) vecs.push_back(ins(TW'(k), 0, k > 0, 0, CW'(k), 1));
    vecs.push_back(ins(5, 1, 1, 0, 8, 0));
    vecs.push_back(idle(0, 1, 1, 7));
    // Insert and issue in the same cycle: new entry lands at count-1.
    vecs.push_back(ins(0, 1, 1, 1, 7, 1));
    vecs.push_back(idle(0, 1, 2, 7));
    vecs.push_back(idle(1, 1, 2, 7));
    vecs.push_back(idle(1, 1, 3, 6));
    vecs.push_back(idle(0, 1, 4, 5));

    foreach (vecs[i]) apply($sformatf("row%0d", i), vecs[i]);

    // Flush with five queued entries (ids 4,5,6,7,0) and both handshakes requested.
    v = mk(1, 1, 6, 0, 1, 0, 1, 0, 0, 1, 0, 0, 5, 1);
    apply("flush", v);
    apply("post_flush0", idle(1, 0, 0, 0));
    apply("post_flush1", idle(0, 0, 0, 0));

    // Asynchronous reset mid-cycle with three entries queued.
    apply("rst_fill0", ins(1, 0, 0, 0, 0, 1));
    apply("rst_fill1", ins(2, 0, 1, 1, 1, 1));
    apply("rst_fill2", ins(3, 0, 1, 1, 2, 1));
    apply("rst_pre", idle(0, 1, 1, 3));
    #1;
    rst = 1'b1;
    #1;
    check_outputs("rst_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    apply("after_rst0", ins(1, 1, 0, 0, 0, 1));
    apply("after_rst1", idle(1, 1, 1, 1));
    apply("after_rst2", idle(0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
Parametrised out-of-order issue buffer that sits between the scoreboard and the functional-unit dispatch logic of the issue stage.
- Generalises the current one-instruction-at-a-time in-order issue path into a DEPTH-entry queue.
- Each entry tracks two source-operand producer tags and wakes up from NR_WB_PORTS writeback ports.
- Each cycle it offers the oldest entry whose operands are both ready.

Parameters:
DEPTH, 8, number of queue entries (≥2)
NR_WB_PORTS, 5, number of writeback/wakeup ports
TAG_W, 3, producer tag (trans_id) width
PAYLOAD_W, 64, opaque instruction payload width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous flush of all entries
in_valid_i  in  1  insert request
in_ready_o  out  1  queue can accept an insert
in_payload_i  in  PAYLOAD_W  instruction payload
in_trans_id_i  in  TAG_W  instruction's own tag
in_rs1_tag_i  in  TAG_W  producer tag of rs1
in_rs1_rdy_i  in  1  rs1 already available
in_rs2_tag_i  in  TAG_W  producer tag of rs2
in_rs2_rdy_i  in  1  rs2 already available
wb_valid_i  in  NR_WB_PORTS  writeback valid per port
wb_tag_i  in  NR_WB_PORTS*TAG_W  writeback tag per port
out_valid_o  out  1  a ready entry is offered
out_ready_i  in  1  FU accepts offered entry
out_payload_o  out  PAYLOAD_W  payload of offered entry
out_trans_id_o  out  TAG_W  tag of offered entry
count_o  out  clog2(DEPTH+1)  occupied entries

Behaviour:
Storage and ordering
- Compacting queue: slot 0 is the oldest entry; valid slots are contiguous from 0.
- Per slot: valid, payload, trans_id, rs1_tag, rs1_rdy, rs2_tag, rs2_rdy.

Reset
- rst_i high clears all valid bits immediately; count_o=0.
- While rst_i is high: out_valid_o=0 and in_ready_o=0. out_payload_o and out_trans_id_o are don't-care when out_valid_o=0.
- Reset asserted mid-operation discards all contents; no handshake completes in that cycle.

Insert
- in_ready_o = (count < DEPTH) & ~rst_i.
- No same-cycle credit from an issue: a full queue stays unready even if it issues that cycle.
- Insert fires on in_valid_i & in_ready_o & ~flush_i.
- The new entry is written to slot count, or slot count-1 if an issue fires in the same cycle.

Same-cycle wakeup bypass
- At insert, rsX_rdy is stored as in_rsX_rdy_i OR (any p: wb_valid_i[p] & wb_tag_i[p]==in_rsX_tag_i).

Wakeup
- Every valid slot with rsX_rdy=0 sets rsX_rdy=1 at the next edge if any p has wb_valid_i[p] & wb_tag_i[p]==rsX_tag.
- All ports are compared in parallel; multiple matching ports are harmless.

Select and issue
- Selected slot = lowest-index valid slot with rs1_rdy & rs2_rdy (combinational from registered state).
- Minimum latencies: insert-to-offer = 1 cycle; wakeup-to-offer = 1 cycle.
- out_valid_o = a selected slot exists & ~rst_i & ~flush_i.
- out_payload_o / out_trans_id_o come from the selected slot.
- Issue fires on out_valid_o & out_ready_i. The selected slot is removed at the edge; all younger slots shift down by one.
- The offered entry is not guaranteed stable while out_ready_i=0: an older slot becoming ready displaces it. The consumer must sample only on handshake.

Flush
- flush_i clears all slots at the next edge; count_o=0.
- An insert and an issue presented in the flush cycle are both dropped.

Count
- count_o = count + insert − issue, saturating is never required (guaranteed by in_ready_o).
- Wrap-around: none. Compaction keeps indices in [0, DEPTH−1].

Test Plan:
1. Reset, then insert A (trans_id=1, rs1/rs2 ready) at cycle 0 -> out_valid_o=1 and out_trans_id_o=1 at cycle 1; with out_ready_i=1, count_o 1→0 at cycle 2.
2. Insert A (id=2, rs1_tag=5, not ready), then B (id=3, ready) -> B offered first. wb_valid_i[3]=1 with tag 5 at cycle t -> A offered at t+1.
3. Insert 8 ready entries with out_ready_i=0 -> in_ready_o=0, count_o=8. Pulse out_ready_i for one cycle -> oldest id issued, count_o=7, in_ready_o=1 next cycle; a simultaneous insert at full is refused.
4. Insert C with rs2_tag=4 not ready while wb_valid_i[0]=1 and wb_tag_i[0]=4 in the same cycle -> C offered next cycle with no further wakeup.
5. Five entries queued; assert flush_i together with in_valid_i=1 and out_ready_i=1 -> no handshake fires, count_o=0 and out_valid_o=0 next cycle.
6. Assert rst_i asynchronously mid-cycle with 3 entries queued -> out_valid_o, in_ready_o and count_o drop to 0 immediately. After release, an insert behaves as in scenario 1.
